// File: rtl/systolic_pkg.sv
// Shared FSM state type and latency helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } state_t;

    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;
    localparam int DEF_PORT_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 22;
    localparam int DEF_A_LAT      = 4;
    localparam int DEF_B_LAT      = 2;
    localparam int DEF_CNT_W      = 16;

    // Activation row r must lag row 0 by the partial-sum hop time of the rows above it.
    function automatic int row_skew(input int r, input int b_lat);
        return r * b_lat;
    endfunction

    // Column c leaves the array (COLS-1-c) activation hops ahead of the last column.
    function automatic int col_deskew(input int c, input int cols, input int a_lat);
        return (cols - 1 - c) * a_lat;
    endfunction

    function automatic int tag_depth(input int array_lat, input int cols, input int a_lat);
        return 1 + array_lat + (cols - 1) * a_lat;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Parameterised delay line; DEPTH 0 degenerates to a plain wire.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-preload / inference sequencer for a weight-stationary PE array.
// Optional SYSTOLIC_CTRL_RELU_EN clamps negative result columns to zero.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int PORT_WIDTH = DEF_PORT_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int A_LAT      = DEF_A_LAT,
    parameter int B_LAT      = DEF_B_LAT,
    parameter int ARRAY_LAT  = ROWS * B_LAT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_vec,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [COLS*PORT_WIDTH-1:0] w_data,
    input  logic                       act_valid,
    output logic                       act_ready,
    input  logic [ROWS*PORT_WIDTH-1:0] act_data,
    output logic                       pe_mode,
    output logic [COLS*PORT_WIDTH-1:0] pe_weight,
    output logic [ROWS*PORT_WIDTH-1:0] pe_a,
    input  logic [COLS*DATA_WIDTH-1:0] arr_b,
    output logic                       res_valid,
    output logic [COLS*DATA_WIDTH-1:0] res_data,
    output logic                       busy,
    output logic                       done
);

    localparam int              TAG_DEPTH = tag_depth(ARRAY_LAT, COLS, A_LAT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t                      state, state_nx;
    logic [CNT_W-1:0]            num_vec_q, w_cnt, acc_cnt, res_cnt;
    logic                        w_beat, act_beat, clr_cnt;
    logic [COLS*PORT_WIDTH-1:0]  w_hold;

    logic [ROWS*PORT_WIDTH-1:0]  act_p0;
    logic                        vld_p0, vld_p1, vld_p2;
    logic signed [DATA_WIDTH-1:0] col_p1 [COLS];
    logic [COLS*DATA_WIDTH-1:0]  res_p2;

    function automatic logic signed [DATA_WIDTH-1:0] post_proc(
        input logic signed [DATA_WIDTH-1:0] x
    );
`ifdef SYSTOLIC_CTRL_RELU_EN
        return x[DATA_WIDTH-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        w_ready   = 1'b0;
        act_ready = 1'b0;
        done      = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_cnt  = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid && w_cnt == CNT_W'(ROWS - 1)) begin
                    if (num_vec_q == '0) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = STREAM;
                    end
                end
            end
            STREAM: begin
                act_ready = 1'b1;
                if (act_valid && (acc_cnt + ONE) == num_vec_q) state_nx = DRAIN;
            end
            DRAIN: begin
                if (res_cnt == num_vec_q) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign w_beat    = w_valid && w_ready;
    assign act_beat  = act_valid && act_ready;
    assign busy      = (state != IDLE);
    assign pe_mode   = w_beat;
    assign pe_weight = w_beat ? w_data : w_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_vec_q <= '0;
            w_cnt     <= '0;
            acc_cnt   <= '0;
            res_cnt   <= '0;
            w_hold    <= '0;
        end else begin
            if (w_beat) w_hold <= w_data;
            if (clr_cnt) begin
                num_vec_q <= num_vec;
                w_cnt     <= '0;
                acc_cnt   <= '0;
                res_cnt   <= '0;
            end else begin
                if (w_beat)   w_cnt   <= w_cnt + ONE;
                if (act_beat) acc_cnt <= acc_cnt + ONE;
                if (vld_p2)   res_cnt <= res_cnt + ONE;
            end
        end
    end

    // Stage p0: input register; bubbles and drain cycles inject zeros with a clear tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            act_p0 <= act_beat ? act_data : '0;
            vld_p0 <= act_beat;
        end
    end

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
            skew_line #(
                .WIDTH (PORT_WIDTH),
                .DEPTH (row_skew(r, B_LAT))
            ) u_skew (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (act_p0[r*PORT_WIDTH +: PORT_WIDTH]),
                .dout  (pe_a[r*PORT_WIDTH +: PORT_WIDTH])
            );
        end

        // Stage p1: columns realigned at the array bottom edge
        for (genvar c = 0; c < COLS; c++) begin : g_col_deskew
            skew_line #(
                .WIDTH (DATA_WIDTH),
                .DEPTH (col_deskew(c, COLS, A_LAT))
            ) u_deskew (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (arr_b[c*DATA_WIDTH +: DATA_WIDTH]),
                .dout  (col_p1[c])
            );
        end
    endgenerate

    // The p0 register is the first tag stage, so the line carries the remainder.
    skew_line #(
        .WIDTH (1),
        .DEPTH (TAG_DEPTH - 1)
    ) u_tag (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (vld_p0),
        .dout  (vld_p1)
    );

    // Stage p2: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            for (int c = 0; c < COLS; c++) begin
                res_p2[c*DATA_WIDTH +: DATA_WIDTH] <= post_proc(col_p1[c]);
            end
        end
    end

    assign res_valid = vld_p2;
    assign res_data  = res_p2;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a behavioural PE-array model driving arr_b.
module tb_systolic_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int PW   = 8;
    localparam int DW   = 22;
    localparam int CW   = 16;
    localparam int A_L  = 4;
    localparam int B_L  = 2;
    localparam int ALAT = 8;
    localparam int LAT  = 22;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [CW-1:0]        num_vec = '0;
    logic                 w_valid = 1'b0;
    logic                 w_ready;
    logic [COLS*PW-1:0]   w_data = '0;
    logic                 act_valid = 1'b0;
    logic                 act_ready;
    logic [ROWS*PW-1:0]   act_data = '0;
    logic                 pe_mode;
    logic [COLS*PW-1:0]   pe_weight;
    logic [ROWS*PW-1:0]   pe_a;
    logic [COLS*DW-1:0]   arr_b = '0;
    logic                 res_valid;
    logic [COLS*DW-1:0]   res_data;
    logic                 busy;
    logic                 done;

    systolic_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .act_data  (act_data),
        .pe_mode   (pe_mode),
        .pe_weight (pe_weight),
        .pe_a      (pe_a),
        .arr_b     (arr_b),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int W [ROWS][COLS];
    logic [ROWS*PW-1:0] hist [64];

    int                 rv_cyc[$];
    logic [COLS*DW-1:0] rv_dat[$];
    int                 done_q[$];
    int                 pm_cyc[$];
    logic [COLS*PW-1:0] pm_dat[$];
    int                 acc_q[$];
    int                 ar_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Array model: row r reaches column c's bottom output ALAT - r*B_L + c*A_L cycles after pe_a.
    always @(negedge clk) begin : array_model
        int s;
        int d;
        logic signed [PW-1:0] a;
        logic [ROWS*PW-1:0] h;
        hist[cyc % 64] = pe_a;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) begin
                d = ALAT - r * B_L + c * A_L;
                h = hist[(cyc - d + 64) % 64];
                a = h[r*PW +: PW];
                s += W[r][c] * int'(a);
            end
            arr_b[c*DW +: DW] = DW'(s);
        end
    end

    always @(negedge clk) begin : monitor
        if (res_valid) begin
            rv_cyc.push_back(cyc);
            rv_dat.push_back(res_data);
        end
        if (done) done_q.push_back(cyc);
        if (pe_mode) begin
            pm_cyc.push_back(cyc);
            pm_dat.push_back(pe_weight);
        end
        if (act_valid && act_ready) acc_q.push_back(cyc);
        if (act_ready) ar_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rv_cyc.delete();
        rv_dat.delete();
        done_q.delete();
        pm_cyc.delete();
        pm_dat.delete();
        acc_q.delete();
        ar_cnt = 0;
    endtask

    function automatic logic [31:0] pk8(input int a0, input int a1, input int a2, input int a3);
        logic [31:0] v;
        v[7:0]   = 8'(a0);
        v[15:8]  = 8'(a1);
        v[23:16] = 8'(a2);
        v[31:24] = 8'(a3);
        return v;
    endfunction

    function automatic logic [COLS*DW-1:0] pk_res(input int c0, input int c1, input int c2, input int c3);
        logic [COLS*DW-1:0] v;
        v[0*DW +: DW] = DW'(c0);
        v[1*DW +: DW] = DW'(c1);
        v[2*DW +: DW] = DW'(c2);
        v[3*DW +: DW] = DW'(c3);
        return v;
    endfunction

    task automatic start_job(input int n);
        start   = 1'b1;
        num_vec = CW'(n);
        tick();
        start   = 1'b0;
    endtask

    // Beats arrive bottom row first, so beat i lands in array row ROWS-1-i.
    task automatic load_rows(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3, input bit gapped);
        logic [31:0] beats [4];
        logic signed [7:0] wv;
        beats = '{b0, b1, b2, b3};
        for (int i = 0; i < ROWS; i++) begin
            for (int c = 0; c < COLS; c++) begin
                wv = beats[i][c*8 +: 8];
                W[ROWS-1-i][c] = int'(wv);
            end
            w_valid = 1'b1;
            w_data  = beats[i];
            tick();
            w_valid = 1'b0;
            if (gapped && i < ROWS - 1) tick();
        end
    endtask

    task automatic send_act(input logic [31:0] v);
        act_valid = 1'b1;
        act_data  = v;
        tick();
        act_valid = 1'b0;
        act_data  = '0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (done_q.size() == 0 && n < maxc) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    task automatic chk_res(input string tag, input int i, input logic [COLS*DW-1:0] exp);
        if (rv_cyc.size() > i && acc_q.size() > i) begin
            chk({tag, "_lat"}, rv_cyc[i] - acc_q[i], LAT);
            chk({tag, "_data"}, rv_dat[i], exp);
        end else begin
            chk({tag, "_present"}, rv_cyc.size(), i + 1);
        end
    endtask

    task automatic chk_done(input string tag, input int nres);
        chk({tag, "_res_n"}, rv_cyc.size(), nres);
        chk({tag, "_done_n"}, done_q.size(), 1);
        if (done_q.size() > 0 && rv_cyc.size() > 0)
            chk({tag, "_done_t"}, done_q[0] - rv_cyc[rv_cyc.size()-1], 1);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) hist[i] = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) W[r][c] = 0;

        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_pe_mode", pe_mode, 1'b0);
        chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_act_ready", act_ready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pe_a", pe_a, '0);
        chk("rst_res_data", res_data, '0);
        rst_n = 1'b1;
        tick();

        // Gapped preload of rows 4,3,2,1 then one vector
        clr();
        start_job(1);
        chk("a_busy", busy, 1'b1);
        chk("a_w_ready", w_ready, 1'b1);
        load_rows(pk8(4,4,4,4), pk8(3,3,3,3), pk8(2,2,2,2), pk8(1,1,1,1), 1'b1);
        chk("a_act_ready", act_ready, 1'b1);
        chk("a_pm_n", pm_cyc.size(), 4);
        if (pm_cyc.size() == 4) begin
            chk("a_pw0", pm_dat[0], pk8(4,4,4,4));
            chk("a_pw3", pm_dat[3], pk8(1,1,1,1));
            for (int i = 1; i < 4; i++) chk($sformatf("a_gap%0d", i), pm_cyc[i] - pm_cyc[i-1], 2);
        end
        send_act(pk8(1,2,3,4));
        wait_done(60);
        chk_res("a_r0", 0, pk_res(30,30,30,30));
        chk_done("a", 1);

        // Unit weights, single vector, start pulse during DRAIN ignored
        clr();
        start_job(1);
        load_rows(pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), 1'b0);
        send_act(pk8(1,2,3,4));
        chk("b_drain_ready", act_ready, 1'b0);
        chk("b_drain_busy", busy, 1'b1);
        start_job(7);
        wait_done(60);
        chk_res("b_r0", 0, pk_res(10,10,10,10));
        chk_done("b", 1);

        // Bubble after the first vector, then back-to-back
        clr();
        start_job(3);
        load_rows(pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), 1'b0);
        send_act(pk8(1,1,1,1));
        tick();
        send_act(pk8(2,2,2,2));
        send_act(pk8(3,3,3,3));
        chk("c_drain_ready", act_ready, 1'b0);
        wait_done(60);
        chk_res("c_r0", 0, pk_res(4,4,4,4));
        chk_res("c_r1", 1, pk_res(8,8,8,8));
        chk_res("c_r2", 2, pk_res(12,12,12,12));
        if (rv_cyc.size() == 3) begin
            chk("c_space01", rv_cyc[1] - rv_cyc[0], 2);
            chk("c_space12", rv_cyc[2] - rv_cyc[1], 1);
        end
        chk_done("c", 3);

        // Zero-length job finishes straight out of LOAD
        clr();
        start_job(0);
        load_rows(pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), 1'b0);
        repeat (5) tick();
        chk("d_done_n", done_q.size(), 1);
        if (done_q.size() == 1 && pm_cyc.size() == 4) chk("d_done_t", done_q[0], pm_cyc[3]);
        chk("d_act_ready_n", ar_cnt, 0);
        chk("d_res_n", rv_cyc.size(), 0);
        chk("d_idle", busy, 1'b0);

        // Reset after two of five vectors
        clr();
        start_job(5);
        load_rows(pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), 1'b0);
        send_act(pk8(1,1,1,1));
        send_act(pk8(2,2,2,2));
        rst_n = 1'b0;
        #1;
        chk("e_busy", busy, 1'b0);
        chk("e_act_ready", act_ready, 1'b0);
        chk("e_pe_mode", pe_mode, 1'b0);
        chk("e_pe_weight", pe_weight, '0);
        chk("e_pe_a", pe_a, '0);
        chk("e_res_data", res_data, '0);
        chk("e_res_valid", res_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        clr();
        repeat (30) tick();
        chk("e_quiet_res", rv_cyc.size(), 0);
        chk("e_quiet_done", done_q.size(), 0);
        chk("e_quiet_busy", busy, 1'b0);
        start_job(1);
        load_rows(pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), pk8(1,1,1,1), 1'b0);
        send_act(pk8(1,2,3,4));
        wait_done(60);
        chk_res("e_r0", 0, pk_res(10,10,10,10));
        chk_done("e", 1);

        // Signed sums -7, 5, 1, 0 across the columns
        clr();
        start_job(1);
        load_rows(pk8(-7,5,1,0), pk8(-7,5,1,0), pk8(-7,5,1,0), pk8(-7,5,1,0), 1'b0);
        send_act(pk8(2,-1,1,-1));
        wait_done(60);
`ifdef SYSTOLIC_CTRL_RELU_EN
        chk_res("f_r0", 0, pk_res(0,5,1,0));
`else
        chk_res("f_r0", 0, pk_res(-7,5,1,0));
`endif
        chk_done("f", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
